pipeline_hazard_unit: RTL
=========================

# pipeline_hazard_unit

Parametrised hazard and forwarding controller for the 5-stage core. It supersedes the single-level, combinational EX/M forwarding compare. It keeps a scoreboard of in-flight destination registers across EX, a configurable number of memory stages and WB. From that scoreboard it produces registered per-operand forwarding selects, load-use stalls and flush-bubble insertion. It sits beside the ID stage and drives the ID_EX operand muxes, PC/IF_ID hold and the ID_EX bubble.

## Interface
Parameters:
- REG_AW, 4: register-number width.
- LOAD_LAT, 1: number of memory stages (M1..M_LOAD_LAT); load data is valid only at WB. Range 1..4.
- SEL_W, derived $clog2(LOAD_LAT+2): forwarding-select width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rn1, id_rn2  in  REG_AW  source register numbers.
- id_use1, id_use2  in  1  operand actually read.
- id_wn  in  REG_AW  destination register.
- id_enrw  in  1  instruction writes the register file.
- id_mr  in  1  instruction is a load.
- flush  in  1  kill the instruction in ID (it does not enter EX).
- stall  out  1  combinational; hold PC and IF_ID, insert a bubble into ID_EX.
- ex_fwd_a, ex_fwd_b  out  SEL_W  registered select for the EX operand. 0 = ID_EX register data; k = result held in stage k (1..LOAD_LAT = M1..Mk, LOAD_LAT+1 = WB).
- stall_cnt  out  32  load-use stall cycles (macro-gated).

## Operation
- Scoreboard has D = LOAD_LAT+2 entries, index 0 = EX … D-1 = WB. Each entry holds {v, wn, ld}. It shifts by one every cycle with no internal hold.
- Entry 0 next value: {1, id_wn, id_mr} when id_valid & id_enrw & !stall & !flush. Otherwise it is a bubble with v=0.
- Match(s, rn) = v[s] & wn[s]==rn. A match is evaluated against the stage the producer will occupy next cycle, which is s+1.
- Load-use stall: stall = id_valid & !flush & OR over operands with use=1 of Match(s, rn) & ld[s], for any s < LOAD_LAT. A load is forwardable only once it is in WB.
- Forward select for an operand with use=1 is the smallest s+1 (youngest producer) such that Match(s, rn) holds, s ≤ D-2, and (!ld[s] or s+1 = D-1). If none, the select is 0. If use=0, the select is 0.
- ex_fwd_a/b load the computed selects when entry 0 loads an instruction. They load 0 on a bubble (stall, flush or !id_valid).
- Producers in WB that are also being read in ID are not tracked. Register_File must be write-through; this is a system requirement.
- Register 0 is not special: all REG_AW values are compared.
- flush and stall together: flush wins. A bubble is inserted and stall is deasserted.

## Timing
- Reset (rst=0, async): all v=0, ex_fwd_a/b=0, stall_cnt=0. stall is then 0 combinationally.
- stall depends on the current scoreboard and the ID inputs only. It has no registered delay.
- Forwarding selects are valid for the whole EX cycle of the consumer, with one-cycle latency from the ID decision.
- Load-use penalty is LOAD_LAT cycles per dependent consumer. With LOAD_LAT=1 this is the classic single bubble.
- Reset released mid-stream: the scoreboard is empty, so the first instructions see no hazards.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt increments once per cycle with stall=1 and saturates at 2^32-1.
- HAZARD_PERF_CNT_EN not defined: stall_cnt is tied to 0 and the counter register is absent.

## Structure
- The shared package core_pkg holds:
  - REG_AW default;
  - the sb_entry_t struct {v, wn, ld};
  - the FWD_NONE = 0 constant.
- One sub-module, hazard_scoreboard, holds the entry shift chain and exposes per-stage match vectors. The top does stall/select priority and the counter.

## Test plan
- ALU chain, LOAD_LAT=1: add r1 then add r2,r1,r3 back-to-back -> stall=0, ex_fwd_a=1 in the second instruction's EX.
- Load-use, LOAD_LAT=1: ld r4 then add r5,r4,r4 -> stall=1 for exactly 1 cycle, then ex_fwd_a=ex_fwd_b=2 (WB).
- Load-use, LOAD_LAT=3: ld r4 then use r4 -> stall for 3 cycles, then select=4. With HAZARD_PERF_CNT_EN defined, stall_cnt=3.
- Double producer: add r1, add r1, use r1 -> select=1 (youngest), not 2.
- flush with a pending load-use: flush=1 on the dependent cycle -> stall=0, a bubble enters EX, ex_fwd_a=0 next cycle.
- Async reset asserted mid-stall: stall drops, selects=0 and stall_cnt=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: register-number defaults, the hazard scoreboard
// entry layout and the "no forwarding" select value.
package core_pkg;

    // Default register-number width of the core.
    localparam int REG_AW_DEFAULT = 4;

    // Widest register number an sb_entry_t can hold; narrower register numbers
    // are zero-extended into the entry.
    localparam int REG_AW_MAX = 8;

    // Forwarding select meaning "use the ID_EX register data".
    localparam int FWD_NONE = 0;

    // One in-flight producer: valid, destination register, is-a-load.
    typedef struct packed {
        logic                  v;
        logic [REG_AW_MAX-1:0] wn;
        logic                  ld;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift chain of in-flight destination registers, one entry per stage from
// EX (index 0) to WB (index DEPTH-1). The chain advances every cycle with no
// hold: a stalled or killed instruction simply becomes a bubble at index 0.
// Exposes per-stage match vectors for both ID source operands.
module hazard_scoreboard
    import core_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int DEPTH  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [REG_AW-1:0] push_wn,
    input  logic              push_ld,
    input  logic [REG_AW-1:0] rn1,
    input  logic [REG_AW-1:0] rn2,
    output logic [DEPTH-1:0]  match1,
    output logic [DEPTH-1:0]  match2,
    output logic [DEPTH-1:0]  ld_vec
);

    sb_entry_t entry_q [DEPTH];
    sb_entry_t entry_d [DEPTH];

    // Entry 0 takes the instruction leaving ID, or a bubble.
    always_comb begin
        entry_d[0] = '0;
        if (push) begin
            entry_d[0].v  = 1'b1;
            entry_d[0].wn = REG_AW_MAX'(push_wn);
            entry_d[0].ld = push_ld;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_shift
            assign entry_d[gi] = entry_q[gi-1];
        end

        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Per-stage entry register, cleared to empty by reset.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry_q[gi] <= '0;
                end else begin
                    entry_q[gi] <= entry_d[gi];
                end
            end

            assign match1[gi] = entry_q[gi].v && (entry_q[gi].wn == REG_AW_MAX'(rn1));
            assign match2[gi] = entry_q[gi].v && (entry_q[gi].wn == REG_AW_MAX'(rn2));
            assign ld_vec[gi] = entry_q[gi].ld;
        end
    endgenerate

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller beside the ID stage. Tracks producers in
// EX, M1..M_LOAD_LAT and WB, raises a combinational load-use stall, and
// registers per-operand forwarding selects for the consumer's EX cycle.
// Optional stall-cycle counter: define HAZARD_PERF_CNT_EN to build it.
module pipeline_hazard_unit
    import core_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEFAULT,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = $clog2(LOAD_LAT + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rn1,
    input  logic [REG_AW-1:0] id_rn2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] id_wn,
    input  logic              id_enrw,
    input  logic              id_mr,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  ex_fwd_a,
    output logic [SEL_W-1:0]  ex_fwd_b,
    output logic [31:0]       stall_cnt
);

    localparam int D = LOAD_LAT + 2;

    // Stages whose load would still be in the memory pipe next cycle.
    localparam logic [D-1:0] STALL_WIN = D'((1 << LOAD_LAT) - 1);
    // Last memory stage: a load there reaches WB next cycle and can forward.
    localparam logic [D-1:0] LAST_MEM  = D'(1) << LOAD_LAT;
    // WB producers are covered by the write-through register file.
    localparam logic [D-1:0] WB_BIT    = D'(1) << (D - 1);

    logic [D-1:0]     match1, match2, ld_vec;
    logic [D-1:0]     fwd_ok, cand1, cand2;
    logic             load_hit1, load_hit2, issue, push;
    logic [SEL_W-1:0] ex_fwd_a_q, ex_fwd_a_d, ex_fwd_b_q, ex_fwd_b_d;

    // Youngest forwardable producer wins; select is its next-cycle stage.
    function automatic logic [SEL_W-1:0] youngest(input logic [D-1:0] cand);
        logic [SEL_W-1:0] sel;
        sel = SEL_W'(FWD_NONE);
        for (int s = D - 2; s >= 0; s--) begin
            if (cand[s]) begin
                sel = SEL_W'(s + 1);
            end
        end
        return sel;
    endfunction

    hazard_scoreboard #(
        .REG_AW (REG_AW),
        .DEPTH  (D)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_wn (id_wn),
        .push_ld (id_mr),
        .rn1     (id_rn1),
        .rn2     (id_rn2),
        .match1  (match1),
        .match2  (match2),
        .ld_vec  (ld_vec)
    );

    // Stall detection, issue decision and next forwarding selects.
    always_comb begin
        load_hit1  = id_use1 && |(match1 & ld_vec & STALL_WIN);
        load_hit2  = id_use2 && |(match2 & ld_vec & STALL_WIN);
        stall      = id_valid && !flush && (load_hit1 || load_hit2);
        issue      = id_valid && !flush && !stall;
        push       = issue && id_enrw;
        fwd_ok     = (~ld_vec | LAST_MEM) & ~WB_BIT;
        cand1      = match1 & fwd_ok;
        cand2      = match2 & fwd_ok;
        ex_fwd_a_d = (issue && id_use1) ? youngest(cand1) : SEL_W'(FWD_NONE);
        ex_fwd_b_d = (issue && id_use2) ? youngest(cand2) : SEL_W'(FWD_NONE);
    end

    // Forwarding select registers, valid during the consumer's EX cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_fwd_a_q <= SEL_W'(FWD_NONE);
            ex_fwd_b_q <= SEL_W'(FWD_NONE);
        end else begin
            ex_fwd_a_q <= ex_fwd_a_d;
            ex_fwd_b_q <= ex_fwd_b_d;
        end
    end

    assign ex_fwd_a = ex_fwd_a_q;
    assign ex_fwd_b = ex_fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stall cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
